pc_unit: RTL and testbench

//  Fetch-stage program counter for the pipelined MIPS core. Holds the PC register and

---
 rtl/pc_unit_if.sv | 37 +++
 rtl/pc_unit.sv | 85 ++++++++
 tb/tb_pc_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-stage PC interface: redirect requests from D/CP0 in, fetch PC and flags out.
// master = pipeline/CP0 side driving requests; slave = the PC unit itself.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             stall;
    logic [WIDTH-1:0] pc_d;
    logic             br_taken;
    logic [15:0]      br_imm16;
    logic             jump;
    logic [25:0]      jump_index;
    logic             jr;
    logic [WIDTH-1:0] jr_target;
    logic             exc_req;
    logic             eret;
    logic [WIDTH-1:0] epc;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus_step;
    logic [WIDTH-1:0] pc_plus_2step;
    logic             redirected;
    logic             adel_f;

    modport master (
        output stall, pc_d, br_taken, br_imm16, jump, jump_index,
               jr, jr_target, exc_req, eret, epc,
        input  pc, pc_plus_step, pc_plus_2step, redirected, adel_f
    );

    modport slave (
        input  stall, pc_d, br_taken, br_imm16, jump, jump_index,
               jr, jr_target, exc_req, eret, epc,
        output pc, pc_plus_step, pc_plus_2step, redirected, adel_f
    );

endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter: selects the next PC from exception, eret, stall,
// register jump, jump, branch and sequential sources, and flags bad fetch addresses.
module pc_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned STEP     = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFF
) (
    input  logic         clk,
    input  logic         reset,
    pc_unit_if.slave     bus
);

    localparam int unsigned STEP2 = 2 * STEP;

    localparam logic [WIDTH-1:0] StepW    = STEP[WIDTH-1:0];
    localparam logic [WIDTH-1:0] Step2W   = STEP2[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ResetPcW = RESET_PC[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ExcVecW  = EXC_VEC[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ImLoW    = IM_LO[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ImHiW    = IM_HI[WIDTH-1:0];

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic             redirected_q, redirected_d;

    logic [WIDTH-1:0] pc_d_p;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] jump_tgt;

    // Branch and jump targets are both relative to the delay-slot PC.
    assign pc_d_p    = bus.pc_d + StepW;
    assign br_offset = {{(WIDTH - 18){bus.br_imm16[15]}}, bus.br_imm16, 2'b00};
    assign br_tgt    = pc_d_p + br_offset;

    if (WIDTH > 28) begin : g_jump_hi
        assign jump_tgt = {pc_d_p[WIDTH-1:28], bus.jump_index, 2'b00};
    end else begin : g_jump_lo
        assign jump_tgt = {bus.jump_index, 2'b00};
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q + StepW;
        redirected_d = 1'b0;
        if (bus.exc_req) begin
            fetch_pc_d   = ExcVecW;
            redirected_d = 1'b1;
        end else if (bus.eret) begin
            fetch_pc_d   = bus.epc;
            redirected_d = 1'b1;
        end else if (bus.stall) begin
            // Redirects seen during a stall are dropped; D re-presents them.
            fetch_pc_d   = fetch_pc_q;
        end else if (bus.jr) begin
            fetch_pc_d   = bus.jr_target;
            redirected_d = 1'b1;
        end else if (bus.jump) begin
            fetch_pc_d   = jump_tgt;
            redirected_d = 1'b1;
        end else if (bus.br_taken) begin
            fetch_pc_d   = br_tgt;
            redirected_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q   <= ResetPcW;
            redirected_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            redirected_q <= redirected_d;
        end
    end

    assign bus.pc            = fetch_pc_q;
    assign bus.pc_plus_step  = fetch_pc_q + StepW;
    assign bus.pc_plus_2step = fetch_pc_q + Step2W;
    assign bus.redirected    = redirected_q;
    assign bus.adel_f        = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q < ImLoW) ||
                               (fetch_pc_q > ImHiW);

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit (WIDTH=32, default addresses).
module tb_pc_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic [31:0] pc_d;
        logic        br;
        logic [15:0] imm;
        logic        jump;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] jr_t;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] e_pc;
        logic        e_red;
        logic        e_adel;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic stall, logic [31:0] pc_d, logic br,
                                logic [15:0] imm, logic jump, logic [25:0] idx, logic jr,
                                logic [31:0] jr_t, logic exc, logic eret, logic [31:0] epc,
                                logic [31:0] e_pc, logic e_red, logic e_adel);
        vec_t v;
        v.rst = rst; v.stall = stall; v.pc_d = pc_d; v.br = br; v.imm = imm;
        v.jump = jump; v.idx = idx; v.jr = jr; v.jr_t = jr_t; v.exc = exc;
        v.eret = eret; v.epc = epc; v.e_pc = e_pc; v.e_red = e_red; v.e_adel = e_adel;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        reset          = v.rst;
        bus.stall      = v.stall;
        bus.pc_d       = v.pc_d;
        bus.br_taken   = v.br;
        bus.br_imm16   = v.imm;
        bus.jump       = v.jump;
        bus.jump_index = v.idx;
        bus.jr         = v.jr;
        bus.jr_target  = v.jr_t;
        bus.exc_req    = v.exc;
        bus.eret       = v.eret;
        bus.epc        = v.epc;
    endtask

    task automatic expect_state(string name, logic [31:0] e_pc, logic e_red, logic e_adel);
        check({name, ".pc"}, bus.pc, e_pc);
        check({name, ".pc_plus_step"}, bus.pc_plus_step, e_pc + 32'd4);
        check({name, ".pc_plus_2step"}, bus.pc_plus_2step, e_pc + 32'd8);
        check({name, ".redirected"}, {31'd0, bus.redirected}, {31'd0, e_red});
        check({name, ".adel_f"}, {31'd0, bus.adel_f}, {31'd0, e_adel});
    endtask

    // One clock edge with the given inputs, then compare.
    task automatic step(vec_t v, string name);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        expect_state(name, v.e_pc, v.e_red, v.e_adel);
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        idle = mk(0, 0, 32'h0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        drive(idle);
        reset = 1'b1;

        //        rst st pc_d          br imm       jp idx         jr jr_t          ex er epc           exp_pc        rd ad
        vecs.push_back(mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,     0, 32'h0,        0, 0, 32'h0,     32'h0000_3000, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,     0, 32'h0,        0, 0, 32'h0,     32'h0000_3000, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     0, 32'h0,        0, 0, 32'h0,     32'h0000_3004, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     0, 32'h0,        0, 0, 32'h0,     32'h0000_3008, 0, 0));
        // backward branch, then one plain cycle
        vecs.push_back(mk(0, 0, 32'h3010,     1, 16'hFFFE, 0, 26'h0,     0, 32'h0,        0, 0, 32'h0,     32'h0000_300C, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     0, 32'h0,        0, 0, 32'h0,     32'h0000_3010, 0, 0));
        vecs.push_back(mk(0, 0, 32'h3000,     0, 16'h0,    1, 26'hC40,   0, 32'h0,        0, 0, 32'h0,     32'h0000_3100, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     1, 32'h3002,     0, 0, 32'h0,     32'h0000_3002, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     0, 32'h0,        0, 0, 32'h0,     32'h0000_3006, 0, 1));
        // stall drops the jump for three cycles, then exception beats stall
        vecs.push_back(mk(0, 1, 32'h3000,     0, 16'h0,    1, 26'hC40,   0, 32'h0,        0, 0, 32'h0,     32'h0000_3006, 0, 1));
        vecs.push_back(mk(0, 1, 32'h3000,     0, 16'h0,    1, 26'hC40,   0, 32'h0,        0, 0, 32'h0,     32'h0000_3006, 0, 1));
        vecs.push_back(mk(0, 1, 32'h3000,     0, 16'h0,    1, 26'hC40,   0, 32'h0,        0, 0, 32'h0,     32'h0000_3006, 0, 1));
        vecs.push_back(mk(0, 1, 32'h0,        0, 16'h0,    0, 26'h0,     0, 32'h0,        1, 0, 32'h0,     32'h0000_4180, 1, 0));
        // top-of-space wrap
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     1, 32'hFFFF_FFFC, 0, 0, 32'h0,     32'hFFFF_FFFC, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     0, 32'h0,        0, 0, 32'h0,     32'h0000_0000, 0, 1));
        // priority: exc > eret > jr; eret beats stall; reset beats exc
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     1, 32'h3200,     1, 1, 32'h3100,  32'h0000_4180, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0,        0, 16'h0,    0, 26'h0,     1, 32'h3200,     0, 1, 32'h3100,  32'h0000_3100, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,     0, 32'h0,        1, 0, 32'h0,     32'h0000_3000, 0, 0));
        vecs.push_back(mk(0, 0, 32'h3000,     1, 16'h0,    1, 26'hC50,   0, 32'h0,        0, 0, 32'h0,     32'h0000_3140, 1, 0));
        vecs.push_back(mk(0, 0, 32'h3000,     0, 16'h0,    1, 26'hC50,   1, 32'h5000,     0, 0, 32'h0,     32'h0000_5000, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     0, 32'h0,        0, 0, 32'h0,     32'h0000_5004, 0, 0));
        // fetch window edges
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     1, 32'h6FFC,     0, 0, 32'h0,     32'h0000_6FFC, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     0, 32'h0,        0, 0, 32'h0,     32'h0000_7000, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     1, 32'h2FFC,     0, 0, 32'h0,     32'h0000_2FFC, 1, 1));
        // jump region taken from pc_d+4, not pc_d
        vecs.push_back(mk(0, 0, 32'h7FFF_FFFC, 0, 16'h0,   1, 26'h1,     0, 32'h0,        0, 0, 32'h0,     32'h8000_0004, 1, 1));
        // branch offset extremes
        vecs.push_back(mk(0, 0, 32'h3000,     1, 16'h7FFF, 0, 26'h0,     0, 32'h0,        0, 0, 32'h0,     32'h0002_3000, 1, 1));
        vecs.push_back(mk(0, 0, 32'h3000,     1, 16'h8000, 0, 26'h0,     0, 32'h0,        0, 0, 32'h0,     32'hFFFE_3004, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,     1, 32'h3004,     0, 0, 32'h0,     32'h0000_3004, 1, 0));

        foreach (vecs[i]) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // jr held through a 4-cycle stall is taken only once the stall drops
        v = idle;
        v.jr = 1'b1; v.jr_t = 32'h4000; v.stall = 1'b1;
        v.e_pc = 32'h3004; v.e_red = 1'b0; v.e_adel = 1'b0;
        for (int i = 0; i < 4; i++) step(v, $sformatf("jr_stall%0d", i));
        v.stall = 1'b0; v.e_pc = 32'h4000; v.e_red = 1'b1;
        step(v, "jr_release");
        v = idle; v.e_pc = 32'h4004;
        step(v, "jr_after");

        // mid-run reset with every redirect raised
        v = idle;
        v.rst = 1'b1; v.exc = 1'b1; v.eret = 1'b1; v.epc = 32'h5000; v.jr = 1'b1;
        v.jr_t = 32'h6000; v.jump = 1'b1; v.br = 1'b1; v.e_pc = 32'h3000;
        step(v, "reset_all");
        v = idle; v.e_pc = 32'h3004;
        step(v, "reset_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
